// File: rtl/mul32_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul32_seq
// Description : Unsigned 32x32->64 radix-2 shift-add multiplier, fixed
//               32-cycle latency, registered busy/done/product outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mul32_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] prod_hi,
   output logic [31:0] prod_lo
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_RUN      = 2'd1;
   localparam logic [1:0] c_DONE     = 2'd2;
   localparam logic [5:0] c_LAST_CNT = 6'd31;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [63:0] r_mcand;
   logic [31:0] r_mplier;
   logic [63:0] r_acc;
   logic [5:0]  r_cnt;
   logic [63:0] w_acc_nxt;
   logic        w_accept;
   logic        w_last;
   logic        w_busy_nxt;
   logic        w_done_nxt;

   // Starts are honoured only when no multiply is in flight.
   assign w_accept  = start && (r_state != c_RUN);
   assign w_last    = (r_state == c_RUN) && (r_cnt == c_LAST_CNT);
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  w_state_nxt = w_accept ? c_RUN : c_IDLE;
         c_RUN:   w_state_nxt = w_last ? c_DONE : c_RUN;
         c_DONE:  w_state_nxt = w_accept ? c_RUN : c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = (w_state_nxt == c_RUN);
      w_done_nxt = w_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         prod_hi <= 32'd0;
         prod_lo <= 32'd0;
      end else begin
         busy <= w_busy_nxt;
         done <= w_done_nxt;
         if (w_last) begin
            prod_hi <= w_acc_nxt[63:32];
            prod_lo <= w_acc_nxt[31:0];
         end
      end
   end

   // Datapath: operands are captured once, then shifted one bit per RUN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= 64'd0;
         r_mplier <= 32'd0;
         r_acc    <= 64'd0;
         r_cnt    <= 6'd0;
      end else if (w_accept) begin
         r_mcand  <= {32'd0, A};
         r_mplier <= B;
         r_acc    <= 64'd0;
         r_cnt    <= 6'd0;
      end else if (r_state == c_RUN) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 6'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul32_seq
// Description : Directed self-checking bench for mul32_seq with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul32_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] prod_hi;
   logic [31:0] prod_lo;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   bit m_en   = 0;

   // Behavioural model state
   bit          m_busy = 0;
   bit          m_done = 0;
   int          m_left = 0;
   logic [63:0] m_prod = 64'd0;
   logic [63:0] m_pend = 64'd0;

   mul32_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .prod_hi (prod_hi),
      .prod_lo (prod_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a start seen while idle yields A*B exactly 32 edges later.
   always @(posedge clk) begin
      bit was_busy;
      if (rst) begin
         m_busy = 0; m_done = 0; m_left = 0; m_prod = 64'd0; m_pend = 64'd0;
      end else begin
         was_busy = m_busy;
         m_done   = 0;
         if (was_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 0;
               m_done = 1;
               m_prod = m_pend;
            end
         end else if (start) begin
            m_busy = 1;
            m_left = 32;
            m_pend = {32'd0, A} * {32'd0, B};
         end
      end
      m_en = 1;
   end

   always @(negedge clk) begin
      if (m_en) begin
         check("busy", {63'd0, busy}, {63'd0, m_busy});
         check("done", {63'd0, done}, {63'd0, m_done});
         check("prod", {prod_hi, prod_lo}, m_prod);
         check("busy_and_done", {63'd0, busy & done}, 64'd0);
         if (done) n_done++;
      end
   end

   // Called on a negedge; returns on the negedge where done is first seen.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int lat);
      start = 1'b1; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      lat = 0;
      while (!done && lat < 40) begin
         if (scramble) begin
            A = $urandom; B = $urandom;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int d0;
      rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_prod", {prod_hi, prod_lo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic
      d0 = n_done;
      run_mul(32'd3, 32'd5, 1'b0, lat);
      check("basic_latency", lat, 32);
      check("basic_prod", {prod_hi, prod_lo}, 64'd15);
      @(negedge clk);
      check("basic_done_once", n_done - d0, 1);

      // Max operands
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
      check("max_latency", lat, 32);
      check("max_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk);

      // Start while busy is ignored
      d0 = n_done;
      start = 1'b1; A = 32'd7; B = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; A = 32'd100; B = 32'd100;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("busy_start_latency", lat, 22);
      check("busy_start_prod", {prod_hi, prod_lo}, 64'd42);
      repeat (40) @(negedge clk);
      check("busy_start_done_once", n_done - d0, 1);

      // Reset mid-operation, with a start coinciding with reset
      d0 = n_done;
      start = 1'b1; A = 32'd9; B = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_prod", {prod_hi, prod_lo}, 64'd0);
      repeat (40) @(negedge clk);
      check("abort_no_done", n_done - d0, 0);
      run_mul(32'd2, 32'h8000_0000, 1'b0, lat);
      check("post_abort_latency", lat, 32);
      check("post_abort_prod", {prod_hi, prod_lo}, 64'h1_0000_0000);
      @(negedge clk);

      // Back-to-back: start held through the DONE cycle
      run_mul(32'h1234, 32'h10, 1'b0, lat);
      check("b2b_first_prod", {prod_hi, prod_lo}, 64'h12340);
      start = 1'b1; A = 32'd0; B = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", {63'd0, busy}, 64'd1);
      check("b2b_hold_prod", {prod_hi, prod_lo}, 64'h12340);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", lat, 32);
      check("b2b_second_prod", {prod_hi, prod_lo}, 64'd0);
      @(negedge clk);

      // Operands scrambled during RUN
      run_mul(32'h10000, 32'h10000, 1'b1, lat);
      check("scramble_latency", lat, 32);
      check("scramble_prod", {prod_hi, prod_lo}, 64'h1_0000_0000);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
